// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU fetch stage.
//   fetch_state_t : fetch controller states (RUN, HOLD, ERR)
//   NOP_INSTR_DEF : default instruction driven when nothing valid is present
//   IMEM_WORDS_DEF: default instruction ROM depth in words
//   INSTR_BYTES   : byte stride between consecutive instructions
//   fetch_addr_bad: true when a fetch address is misaligned or out of range
package cpu_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HOLD = 2'd1,
    ERR  = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR_DEF  = 32'h0000_0000;
  localparam int          IMEM_WORDS_DEF = 64;
  localparam logic [31:0] INSTR_BYTES    = 32'd4;

  // An address is unusable if it is not word aligned or falls at/after the ROM end.
  function automatic logic fetch_addr_bad(input logic [31:0] addr, input logic [31:0] limit);
    return (addr[1:0] != 2'b00) || (addr >= limit);
  endfunction

endpackage

// File: rtl/if_skid_reg.sv
// Load-enabled PC/instruction register pair with synchronous clear.
// Ports:
//   clk, rst_n       : clock and asynchronous active-low reset
//   load, clear      : capture d_* / return to empty (clear wins)
//   d_pc, d_instr    : values to capture
//   q_pc, q_instr    : stored values
module if_skid_reg
  import cpu_pkg::*;
#(
  parameter logic [31:0] CLR_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] d_pc,
  input  logic [31:0] d_instr,
  output logic [31:0] q_pc,
  output logic [31:0] q_instr
);

  // Skid storage: clear has priority so a redirect always empties it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_pc    <= 32'h0000_0000;
      q_instr <= CLR_INSTR;
    end else if (clear) begin
      q_pc    <= 32'h0000_0000;
      q_instr <= CLR_INSTR;
    end else if (load) begin
      q_pc    <= d_pc;
      q_instr <= d_instr;
    end else begin
      q_pc    <= q_pc;
      q_instr <= q_instr;
    end
  end

endmodule

// File: rtl/if_fetch_ctrl.sv
// Fetch-stage controller for a synchronous instruction ROM with one-cycle
// read latency. Owns the PC, drives the ROM address, holds the current
// instruction in a skid register while decode stalls, squashes the wrong-path
// slot on redirect and raises a sticky fault on bad fetch addresses.
// Ports:
//   CLK, RSTn            : clock, asynchronous active-low reset
//   stall                : decode not accepting; hold current IF output
//   redirect, redirect_pc: take redirect_pc this cycle (beats stall)
//   rom_addr / rom_data  : ROM address out, ROM data in (one cycle later)
//   if_valid, if_pc, if_instr : instruction presented to IF/ID
//   fetch_err            : sticky fetch fault, cleared only by reset
module if_fetch_ctrl
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = IMEM_WORDS_DEF,
  parameter logic [31:0] NOP_INSTR  = NOP_INSTR_DEF
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        fetch_err
);

  localparam logic [31:0] IMEM_BYTES = 32'(IMEM_WORDS) * INSTR_BYTES;

  fetch_state_t state, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pend_pc, pend_pc_d;
  logic         pend_v, pend_v_d;
  logic         skid_load, skid_clear;
  logic [31:0]  hold_pc, hold_instr;

  if_skid_reg #(
    .CLR_INSTR(NOP_INSTR)
  ) u_skid (
    .clk    (CLK),
    .rst_n  (RSTn),
    .load   (skid_load),
    .clear  (skid_clear),
    .d_pc   (pend_pc),
    .d_instr(rom_data),
    .q_pc   (hold_pc),
    .q_instr(hold_instr)
  );

  // State, PC and in-flight fetch tracking registers.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state   <= RUN;
      pc_q    <= RESET_PC;
      pend_pc <= 32'h0000_0000;
      pend_v  <= 1'b0;
    end else begin
      state   <= state_d;
      pc_q    <= pc_d;
      pend_pc <= pend_pc_d;
      pend_v  <= pend_v_d;
    end
  end

  // Next-state logic; branches follow the edge-action priority order.
  always_comb begin
    state_d    = state;
    pc_d       = pc_q;
    pend_pc_d  = pend_pc;
    pend_v_d   = pend_v;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    case (state)
      RUN, HOLD: begin
        if (redirect) begin
          if (fetch_addr_bad(redirect_pc, IMEM_BYTES)) begin
            state_d  = ERR;
            pend_v_d = 1'b0;
          end else begin
            // Target issued now; the slot in flight this cycle is squashed.
            pend_pc_d  = redirect_pc;
            pend_v_d   = 1'b1;
            pc_d       = redirect_pc + INSTR_BYTES;
            state_d    = RUN;
            skid_clear = 1'b1;
          end
        end else if (stall) begin
          // The ROM re-reads pc_q while stalled, so pend_pc tracks it.
          pend_pc_d = pc_q;
          if ((state == RUN) && pend_v) begin
            skid_load = 1'b1;
            state_d   = HOLD;
          end else begin
            state_d = state;
          end
        end else begin
          if (pc_q >= IMEM_BYTES) begin
            state_d  = ERR;
            pend_v_d = 1'b0;
          end else begin
            pend_pc_d = pc_q;
            pend_v_d  = 1'b1;
            pc_d      = pc_q + INSTR_BYTES;
            state_d   = RUN;
          end
        end
      end
      ERR: begin
        state_d = ERR;
      end
      default: begin
        state_d  = ERR;
        pend_v_d = 1'b0;
      end
    endcase
  end

  // ROM address and IF output mux.
  always_comb begin
    rom_addr  = redirect ? redirect_pc : pc_q;
    fetch_err = (state == ERR);
    if_valid  = 1'b0;
    if_pc     = pend_pc;
    if_instr  = rom_data;
    case (state)
      RUN: begin
        if_valid = pend_v & ~redirect;
        if_pc    = pend_pc;
        if_instr = rom_data;
      end
      HOLD: begin
        if_valid = ~redirect;
        if_pc    = hold_pc;
        if_instr = hold_instr;
      end
      default: begin
        if_valid = 1'b0;
        if_pc    = pend_pc;
      end
    endcase
    if (!if_valid) begin
      if_instr = NOP_INSTR;
    end else begin
      if_instr = if_instr;
    end
  end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
module tb_if_fetch_ctrl;

  logic        CLK;
  logic        RSTn;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        fetch_err;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t exp_q[$];
  int   total;
  int   bad;

  if_fetch_ctrl dut (
    .CLK        (CLK),
    .RSTn       (RSTn),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .if_valid   (if_valid),
    .if_pc      (if_pc),
    .if_instr   (if_instr),
    .fetch_err  (fetch_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ROM model: word i holds 32'h1000_0000 + i, one-cycle read latency.
  always @(posedge CLK) begin
    if (rom_addr < 32'h100) rom_data <= 32'h1000_0000 + {26'd0, rom_addr[7:2]};
    else                    rom_data <= 32'hDEAD_BEEF;
  end

  // Monitor: every presented instruction must match the next queued expectation.
  always @(negedge CLK) begin
    if (RSTn) begin
      total++;
      if (if_valid) begin
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_valid: got pc=%h instr=%h, wanted no valid output", if_pc, if_instr);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (if_pc !== e.pc || if_instr !== e.instr) begin
            bad++;
            $display("FAIL if_out: got pc=%h instr=%h, wanted pc=%h instr=%h", if_pc, if_instr, e.pc, e.instr);
          end
        end
      end else if (if_instr !== 32'h0000_0000) begin
        bad++;
        $display("FAIL nop_when_invalid: got instr=%h, wanted 00000000", if_instr);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, wanted %h", name, act, exp);
    end
  endtask

  // One cycle of stimulus; ev says whether an instruction is expected this cycle.
  task automatic drive(input logic s, input logic r, input logic [31:0] rpc,
                       input logic ev, input logic [31:0] epc, input logic [31:0] einstr);
    exp_t e;
    @(posedge CLK);
    #1;
    stall       = s;
    redirect    = r;
    redirect_pc = rpc;
    if (ev) begin
      e.pc    = epc;
      e.instr = einstr;
      exp_q.push_back(e);
    end
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    RSTn        = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;

    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_instr", if_instr, 32'h0);
    chk("rst_err", {31'd0, fetch_err}, 32'd0);
    chk("rst_rom_addr", rom_addr, 32'h0);

    @(posedge CLK);
    #1;
    RSTn = 1'b1;
    @(negedge CLK);
    chk("first_cycle_invalid", {31'd0, if_valid}, 32'd0);

    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h00, 32'h1000_0000);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h04, 32'h1000_0001);
    drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h08, 32'h1000_0002);
    drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h08, 32'h1000_0002);
    @(negedge CLK);
    chk("hold_rom_addr", rom_addr, 32'h0C);
    drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h08, 32'h1000_0002);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h08, 32'h1000_0002);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h0C, 32'h1000_0003);
    drive(1'b0, 1'b1, 32'h40, 1'b0, 32'h0, 32'h0);
    @(negedge CLK);
    chk("redir_rom_addr", rom_addr, 32'h40);
    chk("redir_squash", {31'd0, if_valid}, 32'd0);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h40, 32'h1000_0010);
    drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h44, 32'h1000_0011);
    drive(1'b1, 1'b1, 32'h20, 1'b0, 32'h0, 32'h0);
    @(negedge CLK);
    chk("hold_redir_squash", {31'd0, if_valid}, 32'd0);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h20, 32'h1000_0008);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h24, 32'h1000_0009);
    drive(1'b0, 1'b1, 32'h42, 1'b0, 32'h0, 32'h0);
    @(negedge CLK);
    chk("misalign_err_before", {31'd0, fetch_err}, 32'd0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    @(negedge CLK);
    chk("misalign_err", {31'd0, fetch_err}, 32'd1);
    drive(1'b1, 1'b1, 32'h10, 1'b0, 32'h0, 32'h0);
    @(negedge CLK);
    chk("err_ignores_redirect", {31'd0, fetch_err}, 32'd1);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    @(negedge CLK);
    chk("err_sticky", {31'd0, fetch_err}, 32'd1);

    #2;
    RSTn = 1'b0;
    #1;
    chk("async_rst_err", {31'd0, fetch_err}, 32'd0);
    chk("async_rst_valid", {31'd0, if_valid}, 32'd0);
    chk("async_rst_rom_addr", rom_addr, 32'h0);

    @(posedge CLK);
    #1;
    RSTn        = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'hF8;
    @(negedge CLK);
    chk("r0_invalid", {31'd0, if_valid}, 32'd0);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hF8, 32'h1000_003E);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hFC, 32'h1000_003F);
    @(negedge CLK);
    chk("end_err_before", {31'd0, fetch_err}, 32'd0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    @(negedge CLK);
    chk("end_range_err", {31'd0, fetch_err}, 32'd1);
    chk("end_rom_addr", rom_addr, 32'h100);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    @(negedge CLK);
    chk("end_err_sticky", {31'd0, fetch_err}, 32'd1);
    #1;
    chk("missing_outputs", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
